pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline registers replacing the hand-instantiated IF/ID, ID/EX, EX/MEM and MEM/WB registers of the MIPS pipeline.
- Each stage carries a DATA_W payload, a destination register address, a reg-write flag and a valid bit.
- Applies stall (hold plus bubble) and flush uniformly across the chain.
- Produces the forwardA/forwardB mux selects from its own EX/MEM and MEM/WB stage contents.

Parameters:
- DATA_W, 32, payload width per stage.
- STAGES, 4, number of pipeline registers. Legal range 3..8. Index 0 = IF/ID, index STAGES-1 = MEM/WB.
- REG_ADR_W, 5, register address width.
- HOLD_STAGES, 2, number of stages [0..HOLD_STAGES-1] frozen on stall. Stage HOLD_STAGES receives a bubble. Legal range 1..STAGES-2.
- FLUSH_STAGES, 1, number of stages [0..FLUSH_STAGES-1] invalidated on flush. Legal range 1..STAGES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  new entry presented to stage 0.
- in_data  in  DATA_W  stage-0 payload.
- in_dst  in  REG_ADR_W  stage-0 destination register.
- in_wr  in  1  stage-0 reg-write flag.
- stall  in  1  hold-and-bubble request (load-use hazard).
- flush  in  1  squash request (taken branch/jump).
- src_a  in  REG_ADR_W  Rs of the instruction in the EX position.
- src_b  in  REG_ADR_W  Rt of the instruction in the EX position.
- stg_valid  out  STAGES  valid bit per stage, bit k = stage k.
- stg_data  out  STAGES*DATA_W  flattened payloads; stage k at [k*DATA_W +: DATA_W].
- stg_dst  out  STAGES*REG_ADR_W  flattened destination addresses.
- stg_wr  out  STAGES  reg-write flag per stage.
- forwardA  out  2  0 = register file, 1 = MEM/WB, 2 = EX/MEM.
- forwardB  out  2  same encoding as forwardA.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid, data, dst and wr registers clear to 0. forwardA and forwardB read 0. Release of reset is synchronous to clk.
- Normal cycle (stall=0, flush=0): stage 0 loads in_*; stage k loads stage k-1. Latency from input to stage k is k+1 cycles.
- Stall=1: stages 0..HOLD_STAGES-1 keep their contents and in_* is ignored. Stage HOLD_STAGES loads a bubble (valid=0, wr=0, dst=0, data=0). Stages above HOLD_STAGES advance normally.
- Flush=1: stages 0..FLUSH_STAGES-1 load a bubble at the clock edge. Stages at or above FLUSH_STAGES advance normally, or follow stall rules if stall is also asserted.
- Stall and flush together: flush has priority for stages < FLUSH_STAGES. Stall hold/bubble applies to the remaining stages. No entry is duplicated or lost outside the flushed range.
- Bubbles carry wr=0 so they never write the register file or trigger forwarding.
- Forwarding is combinational from registered state. Let E = stage STAGES-2 and W = stage STAGES-1.
  - forwardA = 2 if E.valid & E.wr & E.dst==src_a & src_a!=0.
  - otherwise 1 if W.valid & W.wr & W.dst==src_a & src_a!=0.
  - otherwise 0.
  - forwardB uses src_b with the same rule.
  - When E and W both match, EX/MEM wins (youngest value).
- Register $0 never forwards, regardless of the dst held in a stage.
- Reset asserted mid-operation clears every stage in the same instant; no partial state survives.
- Parameters outside their legal ranges are rejected at elaboration via a generate-time error.

Optional Feature:
- Macro PIPE_PERF_EN.
- When defined:
  - Adds outputs bubble_cnt[15:0] and flush_cnt[15:0].
  - bubble_cnt increments once per clock with stall=1.
  - flush_cnt increments once per clock with flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: neither port nor counter exists, and the core behaviour is identical.

Test Plan:
- Reset with garbage on the inputs, release, 4 idle cycles with in_valid=0 -> stg_valid=4'b0000, forwardA=forwardB=0.
- Stream tokens 0x11,0x22,0x33,0x44 (in_valid=1) on consecutive cycles -> after the 4th edge, stage3..0 data = 0x11,0x22,0x33,0x44 and stg_valid=4'b1111.
- Token 0x55 in stage 0 and 0x66 in stage 1, stall=1 for one cycle -> stages 0/1 still hold 0x55/0x66, stage 2 valid=0, stage 3 holds the old stage-2 entry, in_data ignored.
- Simultaneous flush=1 and stall=1 with FLUSH_STAGES=1, HOLD_STAGES=2 -> stage 0 valid=0, stage 1 holds, stage 2 bubble.
- Stage 2 (dst=8, wr=1) and stage 3 (dst=8, wr=1), src_a=8 -> forwardA=2. Stage 2 with wr=0 -> forwardA=1. src_b=0 with dst=0 in both stages -> forwardB=0.
- PIPE_PERF_EN defined, stall held for 70000 cycles -> bubble_cnt=16'hFFFF. Assert rst=0 mid-run -> counters and all stages read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Parametrised MIPS pipeline register chain with uniform stall/flush and EX-stage forwarding selects.
// Optional PIPE_PERF_EN adds saturating bubble_cnt/flush_cnt counters.
module pipe_stage_chain #(
  parameter int DATA_W       = 32,
  parameter int STAGES       = 4,
  parameter int REG_ADR_W    = 5,
  parameter int HOLD_STAGES  = 2,
  parameter int FLUSH_STAGES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [REG_ADR_W-1:0]        in_dst,
  input  logic                        in_wr,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [REG_ADR_W-1:0]        src_a,
  input  logic [REG_ADR_W-1:0]        src_b,
  output logic [STAGES-1:0]           stg_valid,
  output logic [STAGES*DATA_W-1:0]    stg_data,
  output logic [STAGES*REG_ADR_W-1:0] stg_dst,
  output logic [STAGES-1:0]           stg_wr,
  output logic [1:0]                  forwardA,
  output logic [1:0]                  forwardB
`ifdef PIPE_PERF_EN
  ,
  output logic [15:0]                 bubble_cnt,
  output logic [15:0]                 flush_cnt
`endif
);

  if (STAGES < 3 || STAGES > 8) begin : g_bad_stages
    $error("pipe_stage_chain: STAGES must be in 3..8");
  end
  if (HOLD_STAGES < 1 || HOLD_STAGES > STAGES - 2) begin : g_bad_hold
    $error("pipe_stage_chain: HOLD_STAGES must be in 1..STAGES-2");
  end
  if (FLUSH_STAGES < 1 || FLUSH_STAGES > STAGES) begin : g_bad_flush
    $error("pipe_stage_chain: FLUSH_STAGES must be in 1..STAGES");
  end

  localparam int E = STAGES - 2;
  localparam int W = STAGES - 1;

  logic [STAGES-1:0]                vld_q, vld_d, src_vld;
  logic [STAGES-1:0]                wr_q, wr_d, src_wr;
  logic [STAGES-1:0][DATA_W-1:0]    dat_q, dat_d, src_dat;
  logic [STAGES-1:0][REG_ADR_W-1:0] dst_q, dst_d, src_dst;

  // Value each stage would take on a plain advance: stage 0 from the inputs, stage k from k-1.
  assign src_vld = {vld_q[STAGES-2:0], in_valid};
  assign src_wr  = {wr_q[STAGES-2:0], in_wr};
  assign src_dat = {dat_q[STAGES-2:0], in_data};
  assign src_dst = {dst_q[STAGES-2:0], in_dst};

  always_comb begin
    vld_d = src_vld;
    wr_d  = src_wr;
    dat_d = src_dat;
    dst_d = src_dst;
    for (int k = 0; k < STAGES; k++) begin
      if ((flush && k < FLUSH_STAGES) || (stall && k == HOLD_STAGES)) begin
        vld_d[k] = 1'b0;
        wr_d[k]  = 1'b0;
        dat_d[k] = '0;
        dst_d[k] = '0;
      end else if (stall && k < HOLD_STAGES) begin
        vld_d[k] = vld_q[k];
        wr_d[k]  = wr_q[k];
        dat_d[k] = dat_q[k];
        dst_d[k] = dst_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      dat_q <= '0;
      dst_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      dat_q <= dat_d;
      dst_q <= dst_d;
    end
  end

  assign stg_valid = vld_q;
  assign stg_wr    = wr_q;
  assign stg_data  = dat_q;
  assign stg_dst   = dst_q;

  // Register $0 is hard-wired zero, so it never forwards.
  logic a_e, a_w, b_e, b_w;
  assign a_e = vld_q[E] & wr_q[E] & (dst_q[E] == src_a) & (src_a != '0);
  assign a_w = vld_q[W] & wr_q[W] & (dst_q[W] == src_a) & (src_a != '0);
  assign b_e = vld_q[E] & wr_q[E] & (dst_q[E] == src_b) & (src_b != '0);
  assign b_w = vld_q[W] & wr_q[W] & (dst_q[W] == src_b) & (src_b != '0);

  always_comb begin
    forwardA = 2'd0;
    forwardB = 2'd0;
    if (a_e)      forwardA = 2'd2;
    else if (a_w) forwardA = 2'd1;
    if (b_e)      forwardB = 2'd2;
    else if (b_w) forwardB = 2'd1;
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)  flush_cnt  <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (default parameters); perf counters exercised when PIPE_PERF_EN is defined.
module tb_pipe_stage_chain;
  localparam int DATA_W = 32;
  localparam int STAGES = 4;
  localparam int RA     = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic [RA-1:0]            in_dst;
  logic                     in_wr;
  logic                     stall;
  logic                     flush;
  logic [RA-1:0]            src_a;
  logic [RA-1:0]            src_b;
  logic [STAGES-1:0]        stg_valid;
  logic [STAGES*DATA_W-1:0] stg_data;
  logic [STAGES*RA-1:0]     stg_dst;
  logic [STAGES-1:0]        stg_wr;
  logic [1:0]               forwardA;
  logic [1:0]               forwardB;
`ifdef PIPE_PERF_EN
  logic [15:0]              bubble_cnt;
  logic [15:0]              flush_cnt;
`endif

  pipe_stage_chain #(
    .DATA_W(DATA_W), .STAGES(STAGES), .REG_ADR_W(RA), .HOLD_STAGES(2), .FLUSH_STAGES(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dst(in_dst),
    .in_wr(in_wr), .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
    .stg_valid(stg_valid), .stg_data(stg_data), .stg_dst(stg_dst), .stg_wr(stg_wr),
    .forwardA(forwardA), .forwardB(forwardB)
`ifdef PIPE_PERF_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W+RA:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] sd(input int k);
    return stg_data[k*DATA_W +: DATA_W];
  endfunction

  // One clock: drive inputs, record accepted entries, return just after the edge.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic [RA-1:0] dst,
                     input logic wr, input logic st, input logic fl);
    in_valid = v; in_data = d; in_dst = dst; in_wr = wr; stall = st; flush = fl;
    if (v && !st && !fl) sb_q.push_back({d, dst, wr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Every valid entry leaving MEM/WB must be the oldest accepted, unflushed input.
  always @(negedge clk) begin
    if (rst === 1'b1 && stg_valid[STAGES-1]) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 64'(stg_valid[STAGES-1]), 64'd0);
      end else begin
        logic [DATA_W+RA:0] exp_e;
        exp_e = sb_q.pop_front();
        check("sb_wb_entry",
              64'({stg_data[(STAGES-1)*DATA_W +: DATA_W], stg_dst[(STAGES-1)*RA +: RA], stg_wr[STAGES-1]}),
              64'(exp_e));
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_dst = 5'd5; in_wr = 1'b1;
    stall = 1'b1; flush = 1'b1; src_a = 5'd5; src_b = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(stg_valid), 64'd0);
    check("rst_data", 64'(stg_data[63:0]), 64'd0);
    check("rst_fwd", 64'({forwardA, forwardB}), 64'd0);

    rst = 1'b1;
    idle(4);
    check("idle_valid", 64'(stg_valid), 64'd0);
    check("idle_fwd", 64'({forwardA, forwardB}), 64'd0);

    // Streaming fill
    cyc(1'b1, 32'h11, 5'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 5'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 5'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 5'd4, 1'b0, 1'b0, 1'b0);
    check("fill_valid", 64'(stg_valid), 64'hF);
    check("fill_data", 64'({sd(3), sd(2)}), 64'h00000011_00000022);
    check("fill_data_lo", 64'({sd(1), sd(0)}), 64'h00000033_00000044);

    // Stall: stages 0/1 hold, stage 2 bubbles, stage 3 advances
    cyc(1'b1, 32'h66, 5'd6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h77, 5'd7, 1'b0, 1'b1, 1'b0);
    check("stall_hold", 64'({sd(1), sd(0)}), 64'h00000066_00000055);
    check("stall_valid", 64'(stg_valid), 64'b1011);
    check("stall_s3", 64'(sd(3)), 64'h44);

    // Stall with flush: 0x55 in stage 0 is squashed
    cyc(1'b1, 32'h88, 5'd8, 1'b0, 1'b1, 1'b1);
    void'(sb_q.pop_back());
    check("stfl_valid", 64'(stg_valid), 64'b0010);
    check("stfl_s1", 64'(sd(1)), 64'h66);

    // Flush alone: only the presented input is lost
    cyc(1'b1, 32'hAA, 5'd10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hBB, 5'd11, 1'b0, 1'b0, 1'b1);
    check("flush_valid", 64'(stg_valid), 64'b1010);
    check("flush_data", 64'({sd(3), sd(1)}), 64'h00000066_000000AA);
    idle(4);
    check("sb_drained_1", 64'(sb_q.size()), 64'd0);

    // Forwarding: both E and W match -> EX/MEM wins
    cyc(1'b1, 32'hA1, 5'd8, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 5'd8, 1'b1, 1'b0, 1'b0);
    idle(2);
    src_a = 5'd8; src_b = 5'd8; #1;
    check("fwd_both", 64'({forwardA, forwardB}), 64'b1010);

    // E has wr=0 -> MEM/WB
    cyc(1'b1, 32'hC3, 5'd8, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hD4, 5'd8, 1'b0, 1'b0, 1'b0);
    idle(2);
    src_a = 5'd8; src_b = 5'd3; #1;
    check("fwd_w_only", 64'({forwardA, forwardB}), 64'b0100);

    // $0 never forwards
    cyc(1'b1, 32'hE5, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hF6, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    src_a = 5'd0; src_b = 5'd0; #1;
    check("fwd_r0", 64'({forwardA, forwardB}), 64'd0);

    // Invalid E entry with wr=1 must not forward
    cyc(1'b1, 32'h17, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h29, 5'd9, 1'b1, 1'b0, 1'b0);
    idle(2);
    src_a = 5'd9; src_b = 5'd7; #1;
    check("fwd_invalid", 64'({forwardA, forwardB}), 64'b0001);

    // Distinct E and W destinations
    cyc(1'b1, 32'h3D, 5'd13, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h3C, 5'd12, 1'b1, 1'b0, 1'b0);
    idle(2);
    src_a = 5'd12; src_b = 5'd13; #1;
    check("fwd_split", 64'({forwardA, forwardB}), 64'b1001);
    idle(2);
    check("sb_drained_2", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset mid-cycle
    cyc(1'b1, 32'h101, 5'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h102, 5'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h103, 5'd3, 1'b1, 1'b0, 1'b0);
    src_a = 5'd1; src_b = 5'd0; #1;
    check("pre_arst_fwd", 64'(forwardA), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(stg_valid), 64'd0);
    check("arst_data", 64'(stg_data[63:0] | stg_data[127:64]), 64'd0);
    check("arst_dst_wr", 64'({stg_dst, stg_wr}), 64'd0);
    check("arst_fwd", 64'({forwardA, forwardB}), 64'd0);
    sb_q.delete();

`ifdef PIPE_PERF_EN
    check("perf_rst", 64'({bubble_cnt, flush_cnt}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("perf_flush3", 64'({bubble_cnt, flush_cnt}), 64'h0000_0003);
    in_valid = 1'b0; stall = 1'b1; flush = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("perf_bubble_sat", 64'({bubble_cnt, flush_cnt}), 64'hFFFF_0003);
    #2;
    rst = 1'b0;
    #1;
    check("perf_arst", 64'({bubble_cnt, flush_cnt}), 64'd0);
    check("perf_arst_valid", 64'(stg_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
